muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations, issued from the EX stage beside the single-cycle ALU.
- Accepts one operation, iterates a shared shift/add-subtract datapath for XLEN cycles, then applies sign correction.
- Holds the pipeline via `stall` until the result is valid.
- Selected by the decoder when funct7 = 0000001; funct3 selects the operation.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 6, iteration counter width; must be ≥ clog2(XLEN)+1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request a new operation; sampled only in IDLE or DONE
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  XLEN  rs1 operand; captured on accepted start
- b  input  XLEN  rs2 operand; captured on accepted start
- flush  input  1  abort the in-flight operation (branch mispredict or trap)
- stall  output  1  freeze IF/ID/EX registers
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  final value; held until the next accepted start

Behaviour:
- Clock and reset: one clock (`clk`). Reset (`reset`) is synchronous and active-high.
- Reset values: state = IDLE, busy = 0, done = 0, stall = 0, result = 0, counter = 0, internal registers = 0.
- States:
  - IDLE: waiting.
  - CALC: XLEN iterations.
  - FIX: one cycle of sign correction and result select.
  - DONE: done = 1 for exactly one cycle.
- Transitions:
  - IDLE/DONE with start → CALC, or → DONE directly for special divide cases.
  - CALC with counter = XLEN-1 → FIX.
  - FIX → DONE.
  - DONE without start → IDLE.
- Latency: start accepted at edge T → done high in the cycle after edge T+XLEN+1, i.e. XLEN+2 cycles (34 for XLEN = 32). Special divide cases take 1 cycle (done high after edge T).
- stall = (start & state∈{IDLE,DONE}) | state∈{CALC,FIX}. This is combinational so the issuing instruction holds in EX from its first cycle.
- busy = state∈{CALC,FIX}.
- Operand capture:
  - Signed ops (MULH, DIV, REM; MUL is treated as signed) store |a| and |b|.
  - MULHSU stores |a| and b unsigned.
  - Unsigned ops store the raw values.
  - The negate flag for the final result is latched at capture.
- Multiply:
  - 2·XLEN product register; each CALC cycle adds the multiplicand when the LSB of the multiplier is 1, then shifts right by 1.
  - FIX negates the 64-bit product if the sign flag is set.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- Divide:
  - Restoring algorithm: shift the remainder:quotient pair left, trial-subtract the divisor, keep the result when non-negative, and set the quotient bit.
  - FIX negates the quotient if the signs of a and b differ.
  - FIX negates the remainder if a is negative.
- Special cases, decided at start and skipping CALC:
  - b = 0: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow (a = 0x80000000, b = 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- start while busy: ignored, with no effect on the operation in progress.
- start during DONE: accepted on the same edge; done still pulses in that cycle.
- flush (any state): next state IDLE, no done pulse, result unchanged.
- flush and start in the same cycle: flush wins and start is dropped.
- reset mid-operation: all reset values restored on the next edge.
- The counter is only compared in CALC; it is cleared on entry to CALC.

Decomposition:
- Parametros.v (same PARAM include guard):
  - op codes as named constants (MD_MUL … MD_REMU);
  - state encodings (MD_IDLE, MD_CALC, MD_FIX, MD_DONE).
- Sub-module muldiv_core:
  - holds the product/remainder registers and one iteration step;
  - controlled by init/step/is_div from the FSM in muldiv_sequencer.
- muldiv_sequencer owns the FSM, counter, sign flags, special-case detection and the result register.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) → done after 34 cycles, result 0xFFFFFFEB; stall high for cycles 0..33, low in the done cycle.
- MULHU a=b=0xFFFFFFFF → result 0xFFFFFFFE; MULH with the same operands → 0x00000000; MULHSU a=-1, b=2 → 0xFFFFFFFF.
- DIV a=-7, b=2 → quotient 0xFFFFFFFD; REM a=-7, b=2 → 0xFFFFFFFF; DIVU a=100, b=7 → 14; REMU → 2.
- Divide by zero: DIV a=5, b=0 → 0xFFFFFFFF after 1 cycle; REMU a=5, b=0 → 5. Overflow DIV 0x80000000 / -1 → 0x80000000; REM → 0.
- flush in CALC cycle 10 → no done, busy low next cycle, result keeps its prior value. start pulses during CALC are ignored (operands from the first start are used).
- Back-to-back: start asserted in the DONE cycle with a new op → first result readable in DONE, second done 34 cycles later. Reset asserted mid-CALC → all outputs 0 next edge.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// RV32M multiply/divide sequencer shared definitions.
// Op codes follow funct3; states encode the sequencer FSM.
package muldiv_sequencer_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_CALC = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;
  localparam logic [1:0] MD_DONE = 2'd3;

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM
  function automatic logic op_sgn_a(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV, REM
  function automatic logic op_sgn_b(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Shared shift/add-subtract datapath for unsigned magnitudes.
// hi:lo is the product for multiply, remainder:quotient for divide.
module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shl;
  logic [XLEN+1:0] diff;

  // One iteration: add-and-shift-right, or restoring shift-subtract
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    shl     = {hi_q, lo_q[XLEN-1]};
    diff    = {1'b0, shl} - {2'b00, opb_q};
    if (init) begin
      hi_d  = '0;
      lo_d  = a_mag;
      opb_d = b_mag;
    end else if (step) begin
      if (is_div) begin
        if (!diff[XLEN+1]) begin
          hi_d = diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = shl[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_d = add_sum[XLEN:1];
        lo_d = {add_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      opb_q <= opb_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer issued from EX beside the ALU.
// Owns FSM, counter, sign flags, special cases and result.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN-1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic              idle_or_done;
  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              core_init, core_step;
  logic [XLEN-1:0]   core_hi, core_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  // Operand conditioning and special-case detection at issue
  always_comb begin
    idle_or_done = (state_q == MD_IDLE) || (state_q == MD_DONE);
    accept       = start && idle_or_done && !flush;
    a_neg        = op_sgn_a(op) && a[XLEN-1];
    b_neg        = op_sgn_b(op) && b[XLEN-1];
    a_mag        = a_neg ? -a : a;
    b_mag        = b_neg ? -b : b;
    div_zero     = op[2] && (b == '0);
    ovf          = ((op == MD_DIV) || (op == MD_REM)) &&
                   (a == MIN_NEG) && (b == '1);
    special      = div_zero || ovf;
    special_res  = '0;
    if (div_zero)
      special_res = op[1] ? a : '1;
    else if (ovf)
      special_res = op[1] ? '0 : MIN_NEG;
    core_init    = accept && !special;
    core_step    = (state_q == MD_CALC);
  end

  // Sign correction and result select applied in FIX
  always_comb begin
    prod_fix = neg_quo_q ? -{core_hi, core_lo} : {core_hi, core_lo};
    quo_fix  = neg_quo_q ? -core_lo : core_lo;
    rem_fix  = neg_rem_q ? -core_hi : core_hi;
    if (!op_q[2])
      fix_res = (op_q == MD_MUL) ? prod_fix[XLEN-1:0]
                                 : prod_fix[2*XLEN-1:XLEN];
    else
      fix_res = op_q[1] ? rem_fix : quo_fix;
  end

  // Next-state, counter, captured flags and result register
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    unique case (state_q)
      MD_IDLE, MD_DONE: begin
        state_d = MD_IDLE;
        if (accept) begin
          op_d      = op;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = '0;
          if (special) begin
            state_d  = MD_DONE;
            result_d = special_res;
          end else begin
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST)
          state_d = MD_FIX;
      end
      MD_FIX: begin
        state_d  = MD_DONE;
        result_d = fix_res;
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush) begin
      state_d  = MD_IDLE;
      result_d = result_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .reset  (reset),
    .init   (core_init),
    .step   (core_step),
    .is_div (op_q[2]),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  assign busy   = (state_q == MD_CALC) || (state_q == MD_FIX);
  assign done   = (state_q == MD_DONE);
  assign stall  = (start && idle_or_done) || busy;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer.
// Random and directed ops against a 64-bit arithmetic model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  function automatic logic [31:0] ref_md(input logic [2:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    longint sx;
    longint sy;
    longint uy;
    longint p;
    longint unsigned up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'({32'd0, y});
    case (o)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin
        up = longint'({32'd0, x}) * longint'({32'd0, y});
        return up[63:32];
      end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sx / sy;
        return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        p = sx % sy;
        return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    if (o[2] && y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 &&
        y == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one op from IDLE, wait for done, then return to IDLE.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, output int lat,
                        output logic [31:0] res, output int stall_err,
                        output logic stall_done);
    start = 1'b1; op = o; a = x; b = y;
    #1;
    stall_err = (stall !== 1'b1) ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (stall !== 1'b1) stall_err++;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    stall_done = stall;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", stall); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got %h want 0", result); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [2:0]  ops [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6,
                              3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] xs  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'd5, 32'd5,
                              32'h8000_0000, 32'h8000_0000};
    logic [31:0] ys  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd2, 32'd7, 32'd7, 32'd0,
                              32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] es  [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                              32'h8000_0000, 32'd0};
    int          ls  [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};
    int          lat;
    int          serr;
    logic        sdone;
    logic [31:0] res;
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], xs[i], ys[i], lat, res, serr, sdone);
      total++;
      if (res !== es[i]) begin
        bad++;
        $display("FAIL dir%0d_result op=%0d got %h want %h", i, ops[i], res, es[i]);
      end
      total++;
      if (lat !== ls[i]) begin
        bad++;
        $display("FAIL dir%0d_latency got %0d want %0d", i, lat, ls[i]);
      end
      total++;
      if (serr !== 0 || sdone !== 1'b0) begin
        bad++;
        $display("FAIL dir%0d_stall errs=%0d done_stall=%b want 0/0", i, serr, sdone);
      end
    end
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    int          lat;
    int          serr;
    logic        sdone;
    for (int i = 0; i < 48; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 20));
        3: y = -32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(o, x, y, lat, res, serr, sdone);
      total++;
      if (res !== ref_md(o, x, y) || lat !== ref_lat(o, x, y)) begin
        bad++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got %h/%0d want %h/%0d",
                 i, o, x, y, res, lat, ref_md(o, x, y), ref_lat(o, x, y));
      end
    end
  endtask

  task automatic test_flush;
    int          lat;
    int          serr;
    int          seen;
    logic        sdone;
    logic [31:0] res;
    run_op(3'd0, 32'd3, 32'd5, lat, res, serr, sdone);
    total++;
    if (res !== 32'd15) begin bad++; $display("FAIL flush_pre got %h want f", res); end
    start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL flush_calc busy=%b done=%b want 0/0", busy, done);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL flush_nodone got %0d pulses want 0", seen); end
    total++;
    if (result !== 32'd15) begin bad++; $display("FAIL flush_hold got %h want f", result); end
    start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL flush_start busy=%b done=%b want 0/0", busy, done);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_start_ignored;
    int lat;
    start = 1'b1; op = 3'd0; a = 32'd1234; b = 32'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (lat % 5 == 0) begin
        start = 1'b1;
        op = 3'($urandom_range(0, 7));
        a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    total++;
    if (result !== 32'd7006652 || lat !== 34) begin
      bad++;
      $display("FAIL start_ignored got %h/%0d want %h/34", result, lat, 32'd7006652);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (result !== 32'd14 || lat !== 34) begin
      bad++; $display("FAIL b2b_first got %h/%0d want e/34", result, lat);
    end
    start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
    #1;
    total++;
    if (done !== 1'b1 || stall !== 1'b1) begin
      bad++; $display("FAIL b2b_issue done=%b stall=%b want 1/1", done, stall);
    end
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (result !== 32'd42 || lat !== 34) begin
      bad++; $display("FAIL b2b_second got %h/%0d want 2a/34", result, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset;
    start = 1'b1; op = 3'd3; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset busy=%b done=%b stall=%b result=%h want all 0",
               busy, done, stall, result);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
